// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer feeding DDS_top: steps the FTW from start to stop with a per-step dwell.
// Single, repeating-sawtooth and triangle profiles; all outputs registered, config shadowed on start.
module dds_sweep_ctrl #(
    parameter int FTW_W   = 6,
    parameter int DWELL_W = 8,
    parameter int AMP_W   = 6
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               start_in,
    input  logic               abort_in,
    input  logic [1:0]         mode_in,
    input  logic [FTW_W-1:0]   ftw_start_in,
    input  logic [FTW_W-1:0]   ftw_stop_in,
    input  logic [FTW_W-1:0]   ftw_step_in,
    input  logic [DWELL_W-1:0] dwell_in,
    input  logic [1:0]         wavesel_in,
    input  logic [AMP_W-1:0]   amp_in,
    output logic [FTW_W-1:0]   ftw_out,
    output logic [1:0]         wavesel_out,
    output logic [AMP_W-1:0]   amp_out,
    output logic               nco_enable_out,
    output logic               busy_out,
    output logic               done_out,
    output logic               err_out
);

    typedef enum logic {S_IDLE = 1'b0, S_SWEEP = 1'b1} state_t;

    localparam logic [1:0] MODE_REPEAT   = 2'b01;
    localparam logic [1:0] MODE_TRIANGLE = 2'b10;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0]         r_mode;
    logic [FTW_W-1:0]   r_start;
    logic [FTW_W-1:0]   r_stop;
    logic [FTW_W-1:0]   r_step;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic               r_dir_dn;
    logic [FTW_W-1:0]   r_ftw;
    logic [1:0]         r_wavesel;
    logic [AMP_W-1:0]   r_amp;
    logic               r_en;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic               w_cfg_bad;
    logic               w_start_ok;
    logic               w_step_now;
    logic               w_leg_end_up;
    logic               w_single;
    logic [FTW_W:0]     w_sum;
    logic [FTW_W:0]     w_diff;
    logic [FTW_W-1:0]   w_up_nxt;
    logic [FTW_W-1:0]   w_dn_nxt;

    logic [DWELL_W-1:0] w_dwell_cnt_nxt;
    logic               w_dir_dn_nxt;
    logic [FTW_W-1:0]   w_ftw_nxt;
    logic [1:0]         w_wavesel_nxt;
    logic [AMP_W-1:0]   w_amp_nxt;
    logic               w_en_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_err_nxt;
    logic               w_load;

    assign w_cfg_bad  = (ftw_step_in == '0) || (ftw_start_in > ftw_stop_in);
    assign w_start_ok = start_in && !abort_in && !w_cfg_bad && (r_state == S_IDLE);
    assign w_step_now = (r_dwell_cnt == '0);
    assign w_single   = (r_mode != MODE_REPEAT) && (r_mode != MODE_TRIANGLE);
    assign w_leg_end_up = w_step_now && !r_dir_dn && (r_ftw == r_stop);

    // Extra MSB catches overflow/borrow so the FTW clamps instead of wrapping.
    // At a leg turnaround r_ftw equals the opposite endpoint, so these also give the turn values.
    assign w_sum    = {1'b0, r_ftw} + {1'b0, r_step};
    assign w_diff   = {1'b0, r_ftw} - {1'b0, r_step};
    assign w_up_nxt = (w_sum > {1'b0, r_stop}) ? r_stop : w_sum[FTW_W-1:0];
    assign w_dn_nxt = (w_diff[FTW_W] || (w_diff[FTW_W-1:0] < r_start)) ? r_start
                                                                      : w_diff[FTW_W-1:0];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_mode      <= '0;
            r_start     <= '0;
            r_stop      <= '0;
            r_step      <= '0;
            r_dwell     <= '0;
            r_dwell_cnt <= '0;
            r_dir_dn    <= 1'b0;
            r_ftw       <= '0;
            r_wavesel   <= '0;
            r_amp       <= '0;
            r_en        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_dwell_cnt <= w_dwell_cnt_nxt;
            r_dir_dn    <= w_dir_dn_nxt;
            r_ftw       <= w_ftw_nxt;
            r_wavesel   <= w_wavesel_nxt;
            r_amp       <= w_amp_nxt;
            r_en        <= w_en_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            if (w_load) begin
                r_mode  <= mode_in;
                r_start <= ftw_start_in;
                r_stop  <= ftw_stop_in;
                r_step  <= ftw_step_in;
                r_dwell <= dwell_in;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort_in) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_start_ok) w_state_nxt = S_SWEEP;
                S_SWEEP: if (w_leg_end_up && w_single) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_dwell_cnt_nxt = r_dwell_cnt;
        w_dir_dn_nxt    = r_dir_dn;
        w_ftw_nxt       = r_ftw;
        w_wavesel_nxt   = r_wavesel;
        w_amp_nxt       = r_amp;
        w_en_nxt        = r_en;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_err_nxt       = r_err;
        w_load          = 1'b0;
        if (abort_in) begin
            w_ftw_nxt  = '0;
            w_en_nxt   = 1'b0;
            w_busy_nxt = 1'b0;
        end else if (r_state == S_IDLE) begin
            if (start_in && w_cfg_bad) begin
                w_err_nxt  = 1'b1;
                w_done_nxt = 1'b1;
            end else if (start_in) begin
                w_load          = 1'b1;
                w_ftw_nxt       = ftw_start_in;
                w_en_nxt        = 1'b1;
                w_busy_nxt      = 1'b1;
                w_err_nxt       = 1'b0;
                w_dwell_cnt_nxt = dwell_in;
                w_dir_dn_nxt    = 1'b0;
                w_wavesel_nxt   = wavesel_in;
                w_amp_nxt       = amp_in;
            end
        end else if (!w_step_now) begin
            w_dwell_cnt_nxt = r_dwell_cnt - DWELL_W'(1);
        end else begin
            w_dwell_cnt_nxt = r_dwell;
            if (!r_dir_dn) begin
                if (r_ftw != r_stop) begin
                    w_ftw_nxt = w_up_nxt;
                end else if (r_mode == MODE_REPEAT) begin
                    w_ftw_nxt = r_start;
                end else if (r_mode == MODE_TRIANGLE) begin
                    w_dir_dn_nxt = 1'b1;
                    w_ftw_nxt    = w_dn_nxt;
                end else begin
                    w_busy_nxt = 1'b0;
                    w_done_nxt = 1'b1;
                end
            end else begin
                if (r_ftw != r_start) begin
                    w_ftw_nxt = w_dn_nxt;
                end else begin
                    w_dir_dn_nxt = 1'b0;
                    w_ftw_nxt    = w_up_nxt;
                end
            end
        end
    end

    assign ftw_out        = r_ftw;
    assign wavesel_out    = r_wavesel;
    assign amp_out        = r_amp;
    assign nco_enable_out = r_en;
    assign busy_out       = r_busy;
    assign done_out       = r_done;
    assign err_out        = r_err;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed scenarios plus randomized configs against a step-list model.
module tb_dds_sweep_ctrl;
    localparam int FW = 6;
    localparam int DW = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [1:0]    mode, ws;
    logic [FW-1:0] fs, fe, fst;
    logic [DW-1:0] dw;
    logic [AW-1:0] amp;
    logic [FW-1:0] ftw_o;
    logic [1:0]    ws_o;
    logic [AW-1:0] amp_o;
    logic          en_o, busy_o, done_o, err_o;

    always #5 clk = ~clk;

    dds_sweep_ctrl #(.FTW_W(FW), .DWELL_W(DW), .AMP_W(AW)) dut (
        .clk_in(clk), .rst_in(rst), .start_in(start), .abort_in(abort),
        .mode_in(mode), .ftw_start_in(fs), .ftw_stop_in(fe), .ftw_step_in(fst),
        .dwell_in(dw), .wavesel_in(ws), .amp_in(amp),
        .ftw_out(ftw_o), .wavesel_out(ws_o), .amp_out(amp_o),
        .nco_enable_out(en_o), .busy_out(busy_o), .done_out(done_o), .err_out(err_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    int m_ftw, m_en, m_err, m_ws, m_amp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int f, input int en, input int busy,
                             input int done, input int err, input int w, input int a);
        chk({tag, ".ftw"},  32'(ftw_o),  f);
        chk({tag, ".en"},   32'(en_o),   en);
        chk({tag, ".busy"}, 32'(busy_o), busy);
        chk({tag, ".done"}, 32'(done_o), done);
        chk({tag, ".err"},  32'(err_o),  err);
        chk({tag, ".ws"},   32'(ws_o),   w);
        chk({tag, ".amp"},  32'(amp_o),  a);
    endtask

    // Inputs while busy must be ignored, so they are thrown around freely.
    task automatic scramble();
        start = 1'($urandom_range(0, 1));
        mode  = 2'($urandom);
        fs    = FW'($urandom);
        fe    = FW'($urandom);
        fst   = FW'($urandom);
        dw    = DW'($urandom);
        ws    = 2'($urandom);
        amp   = AW'($urandom);
    endtask

    // Sequence of FTW values visited, one entry per dwell period.
    task automatic build_seq(input int md, input int s, input int e, input int st, input int maxn);
        int f;
        int lst[$];
        exp_q.delete();
        f = s;
        if (md == 2) begin
            exp_q.push_back(s);
            while (exp_q.size() < maxn) begin
                while (f != e) begin f = (f + st > e) ? e : f + st; exp_q.push_back(f); end
                while (f != s) begin f = (f - st < s) ? s : f - st; exp_q.push_back(f); end
                if (s == e) exp_q.push_back(s);
            end
        end else begin
            lst.push_back(f);
            while (f != e) begin f = (f + st > e) ? e : f + st; lst.push_back(f); end
            if (md == 1) begin
                while (exp_q.size() < maxn) begin
                    foreach (lst[i]) exp_q.push_back(lst[i]);
                end
            end else begin
                exp_q = lst;
            end
        end
    endtask

    task automatic do_abort(input int use_rst);
        if (use_rst != 0) rst = 1'b1; else abort = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0; abort = 1'b0; start = 1'b0;
        m_ftw = 0; m_en = 0;
        if (use_rst != 0) begin m_ws = 0; m_amp = 0; m_err = 0; end
        check_all(use_rst != 0 ? "rst" : "abort", 0, 0, 0, 0, m_err, m_ws, m_amp);
        tick();
        check_all("post_abort", 0, 0, 0, 0, m_err, m_ws, m_amp);
    endtask

    task automatic run_sweep(input int md, input int s, input int e, input int st, input int d,
                             input int w, input int a, input int stop_at, input int use_rst);
        int cyc;
        bit single;
        mode = 2'(md); fs = FW'(s); fe = FW'(e); fst = FW'(st); dw = DW'(d);
        ws = 2'(w); amp = AW'(a); abort = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        if (st == 0 || s > e) begin
            m_err = 1;
            check_all("cfg_err", m_ftw, m_en, 0, 1, 1, m_ws, m_amp);
            tick();
            check_all("cfg_err_hold", m_ftw, m_en, 0, 0, 1, m_ws, m_amp);
            return;
        end
        single = (md == 0 || md == 3);
        build_seq(md, s, e, st, 12);
        m_ws = w; m_amp = a; m_err = 0;
        cyc = 0;
        foreach (exp_q[i]) begin
            for (int k = 0; k <= d; k++) begin
                if (stop_at >= 0 && cyc == stop_at) begin
                    do_abort(use_rst);
                    return;
                end
                check_all("sweep", exp_q[i], 1, 1, 0, 0, m_ws, m_amp);
                scramble();
                cyc++;
                tick();
            end
        end
        if (single) begin
            start = 1'b0;
            check_all("done", e, 1, 0, 1, 0, m_ws, m_amp);
            tick();
            check_all("hold", e, 1, 0, 0, 0, m_ws, m_amp);
            m_ftw = e; m_en = 1;
        end else begin
            do_abort(0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = '0; fs = '0; fe = '0; fst = '0;
        dw = '0; ws = '0; amp = '0;
        m_ftw = 0; m_en = 0; m_err = 0; m_ws = 0; m_amp = 0;
        tick();
        tick();
        rst = 1'b0;
        check_all("reset", 0, 0, 0, 0, 0, 0, 0);

        run_sweep(0, 4, 12, 3, 2, 1, 33, -1, 0);
        run_sweep(0, 60, 63, 5, 0, 2, 63, -1, 0);
        run_sweep(2, 2, 8, 3, 0, 3, 17, -1, 0);
        run_sweep(1, 2, 8, 3, 0, 1, 9, -1, 0);
        run_sweep(0, 10, 5, 1, 0, 2, 5, -1, 0);
        run_sweep(0, 3, 9, 0, 0, 2, 5, -1, 0);
        run_sweep(0, 4, 12, 3, 2, 1, 21, 3, 0);
        run_sweep(1, 4, 12, 3, 2, 2, 44, 5, 1);
        run_sweep(0, 4, 12, 3, 2, 1, 33, -1, 0);
        run_sweep(3, 1, 20, 7, 1, 3, 12, -1, 0);
        run_sweep(0, 7, 7, 2, 1, 1, 7, -1, 0);
        run_sweep(2, 7, 7, 2, 1, 2, 8, -1, 0);
        run_sweep(1, 7, 7, 2, 0, 0, 3, -1, 0);
        run_sweep(2, 2, 9, 3, 1, 1, 4, -1, 0);

        for (int n = 0; n < 60; n++) begin
            int s, e, st;
            s  = $urandom_range(0, 63);
            e  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(s, 63);
            st = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 63);
            run_sweep($urandom_range(0, 3), s, e, st, $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 63),
                      ($urandom_range(0, 2) == 0) ? $urandom_range(0, 30) : -1,
                      ($urandom_range(0, 5) == 0) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
